// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg
// Shared definitions for the instruction fetch stage: fetch FSM state
// encoding and the geometry of the 8-byte instruction-memory line.
package mips_fetch_pkg;

    typedef enum logic {
        RUN  = 1'b0,   // serving instructions from the line buffer
        WAIT = 1'b1    // line request outstanding, counting memory latency
    } fetch_state_t;

    localparam int LINE_BYTES  = 8;
    localparam int INSTR_BYTES = 4;
    localparam int LINE_OFF_W  = 3;                 // byte offset within a line
    localparam int TAG_W       = 16 - LINE_OFF_W;   // line number, 13 bits

endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if
// 64-bit instruction-memory read port.
//   mem_addr  : 16-bit line-aligned byte address (bits [2:0] always 0)
//   mem_rdata : 64-bit line, byte k of the line in bits [8k+7:8k]
// master = fetch stage (drives the address), slave = memory.
interface instruction_fetch_if;
    logic [15:0] mem_addr;
    logic [63:0] mem_rdata;

    modport master (output mem_addr, input  mem_rdata);
    modport slave  (input  mem_addr, output mem_rdata);
endinterface

// File: rtl/instruction_fetch_line_buffer.sv
// fetch_line_buffer
// One-line instruction buffer: holds line data, tag and valid, performs the
// hit compare against the current PC and selects the 32-bit word.
// Ports:
//   clk, rst_n    : clock, async active-low reset (clears line/tag/valid)
//   i_fill        : capture i_fill_line / i_fill_tag this edge
//   i_fill_tag    : line number of the line being captured
//   i_fill_line   : 64-bit line from memory
//   i_pc_tag      : line number of the current PC
//   i_word_sel    : PC bit 2, selects upper/lower word
//   o_hit         : buffer valid and tag matches the PC
//   o_instr       : selected word (driven even when not a hit)
module fetch_line_buffer
    import mips_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_fill,
    input  logic [TAG_W-1:0] i_fill_tag,
    input  logic [63:0]      i_fill_line,
    input  logic [TAG_W-1:0] i_pc_tag,
    input  logic             i_word_sel,
    output logic             o_hit,
    output logic [31:0]      o_instr
);
    logic [63:0]      r_line;
    logic [TAG_W-1:0] r_tag;
    logic             r_valid;

    // The buffer is only ever overwritten; valid drops only on reset since
    // instruction memory is read-only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line  <= '0;
            r_tag   <= '0;
            r_valid <= 1'b0;
        end else if (i_fill) begin
            r_line  <= i_fill_line;
            r_tag   <= i_fill_tag;
            r_valid <= 1'b1;
        end
    end

    assign o_hit   = r_valid && (r_tag == i_pc_tag);
    assign o_instr = i_word_sel ? r_line[63:32] : r_line[31:0];
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch
// Pipelined-MIPS fetch stage. Owns the PC, requests 8-byte lines from
// instruction memory, waits MEM_LATENCY cycles, captures the line into a
// one-line buffer and serves one 32-bit instruction per cycle on hits.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   stall         : decode cannot accept, hold the current instruction
//   redirect      : load redirect_pc (bits [1:0] ignored) as the new PC
//   imem          : memory port (mem_addr out, mem_rdata in)
//   instr         : instruction word at instr_pc
//   instr_pc      : current PC
//   instr_valid   : instr is valid this cycle
//   miss_count    : saturating count of line requests issued after reset
//                   (present only when IFETCH_STATS_EN is defined)
module instruction_fetch
    import mips_fetch_pkg::*;
#(
    parameter int          MEM_LATENCY = 5,
    parameter logic [15:0] RESET_PC    = 16'h0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                redirect,
    input  logic [15:0]         redirect_pc,
    instruction_fetch_if.master imem,
    output logic [31:0]         instr,
    output logic [15:0]         instr_pc,
    output logic                instr_valid
`ifdef IFETCH_STATS_EN
    ,
    output logic [15:0]         miss_count
`endif
);
    localparam int               CNT_W    = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(MEM_LATENCY);

    fetch_state_t     r_state, w_state_nxt;
    logic [15:0]      r_pc, w_pc_nxt;
    logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
    logic [TAG_W-1:0] r_mem_tag, w_mem_tag_nxt;   // line currently requested
    logic [15:0]      w_target;
    logic             w_far_redirect;
    logic             w_hit, w_fill;
    logic [31:0]      w_instr;

    assign w_target = redirect_pc & 16'hFFFC;
    // A redirect outside the line being fetched must restart the request.
    assign w_far_redirect = redirect && (w_target[15:LINE_OFF_W] != r_mem_tag);

    fetch_line_buffer u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_fill      (w_fill),
        .i_fill_tag  (r_mem_tag),
        .i_fill_line (imem.mem_rdata),
        .i_pc_tag    (r_pc[15:LINE_OFF_W]),
        .i_word_sel  (r_pc[2]),
        .o_hit       (w_hit),
        .o_instr     (w_instr)
    );

    assign instr         = w_instr;
    assign instr_pc      = r_pc;
    assign instr_valid   = w_hit && (r_state == RUN);
    assign imem.mem_addr = {r_mem_tag, {LINE_OFF_W{1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= WAIT;
            r_pc       <= RESET_PC & 16'hFFFC;
            r_wait_cnt <= '0;
            r_mem_tag  <= RESET_PC[15:LINE_OFF_W];
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_mem_tag  <= w_mem_tag_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_wait_cnt_nxt = r_wait_cnt;
        w_mem_tag_nxt  = r_mem_tag;
        w_fill         = 1'b0;
        case (r_state)
            RUN: begin
                // A redirect only moves the PC; a miss on the new PC is
                // detected on the following cycle.
                if (redirect) begin
                    w_pc_nxt = w_target;
                end else if (!w_hit) begin
                    w_mem_tag_nxt  = r_pc[15:LINE_OFF_W];
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = WAIT;
                end else if (!stall) begin
                    w_pc_nxt = r_pc + 16'd4;   // wraps 0xFFFC -> 0x0000
                end
            end
            WAIT: begin
                if (w_far_redirect) begin
                    w_pc_nxt       = w_target;
                    w_mem_tag_nxt  = w_target[15:LINE_OFF_W];
                    w_wait_cnt_nxt = '0;
                end else begin
                    // Same-line redirect leaves the outstanding fill alone.
                    if (redirect) w_pc_nxt = w_target;
                    if (r_wait_cnt == CNT_DONE) begin
                        w_fill      = 1'b1;
                        w_state_nxt = RUN;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = WAIT;
        endcase
    end

`ifdef IFETCH_STATS_EN
    logic [15:0] r_miss_cnt;
    logic        w_issue;

    assign w_issue = ((r_state == RUN) && !redirect && !w_hit) ||
                     ((r_state == WAIT) && w_far_redirect);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_miss_cnt <= '0;
        else if (w_issue && (r_miss_cnt != 16'hFFFF))
            r_miss_cnt <= r_miss_cnt + 16'd1;
    end

    assign miss_count = r_miss_cnt;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
    localparam int L = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
`ifdef IFETCH_STATS_EN
    logic [15:0] miss_count;
`endif

    int checks = 0;
    int failures = 0;

    instruction_fetch_if imem();

    instruction_fetch #(.MEM_LATENCY(L), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid)
`ifdef IFETCH_STATS_EN
        ,
        .miss_count  (miss_count)
`endif
    );

    always #5 clk = ~clk;

    // Memory contents: byte at address a. Addresses 0..7 hold 0..7.
    function automatic logic [7:0] mbyte(input logic [15:0] a);
        return a[7:0] + a[15:8] * 8'd37;
    endfunction

    function automatic logic [31:0] mword(input logic [15:0] a);
        return {mbyte(a + 16'd3), mbyte(a + 16'd2), mbyte(a + 16'd1), mbyte(a)};
    endfunction

    function automatic logic [63:0] mline(input logic [15:0] a);
        logic [63:0] l;
        l = '0;
        for (int k = 0; k < 8; k++) l[8*k +: 8] = mbyte(a + 16'(k));
        return l;
    endfunction

    // Memory returns real data only once the address has been held for L
    // sampling edges; otherwise a poison pattern.
    int          held;
    logic [15:0] last_addr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held      <= 0;
            last_addr <= imem.mem_addr;
        end else if (imem.mem_addr == last_addr) begin
            held <= held + 1;
        end else begin
            held      <= 1;
            last_addr <= imem.mem_addr;
        end
    end
    assign imem.mem_rdata = (held >= L) ? mline(imem.mem_addr) : 64'hDEAD_BEEF_DEAD_BEEF;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_redirect(input logic [15:0] t);
        redirect    = 1'b1;
        redirect_pc = t;
        tick();
        redirect    = 1'b0;
    endtask

    task automatic wait_valid(output int gap);
        gap = 0;
        while (!instr_valid && gap < 40) begin
            tick();
            gap++;
        end
    endtask

    initial begin
        int          gap;
        int          streak;
        logic [15:0] pc_m, nxt, tgt;
        logic        prev_v;
        logic [12:0] prev_line;

        // ---- reset state
        tick(); tick();
        chk1 ("rst_valid", instr_valid, 1'b0);
        chk32("rst_instr", instr, 32'h0);
        chk16("rst_pc", instr_pc, 16'h0000);
        chk16("rst_maddr", imem.mem_addr, 16'h0000);
        rst_n = 1'b1;

        // ---- first fill: valid after edge L+1
        for (int e = 1; e <= L; e++) begin
            tick();
            chk1("boot_fill_valid", instr_valid, 1'b0);
        end
        tick();
        chk1 ("boot_valid", instr_valid, 1'b1);
        chk32("boot_instr", instr, 32'h03020100);
        chk16("boot_pc", instr_pc, 16'h0000);
        tick();
        chk1 ("seq_valid", instr_valid, 1'b1);
        chk32("seq_instr", instr, 32'h07060504);
        chk16("seq_pc", instr_pc, 16'h0004);

        // ---- stall 3 cycles on a hit
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk16("stall_pc", instr_pc, 16'h0004);
            chk1 ("stall_valid", instr_valid, 1'b1);
        end
        stall = 1'b0;

        // ---- line crossing: 7 invalid cycles, mem_addr held
        tick();
        chk16("cross_pc", instr_pc, 16'h0008);
        chk1 ("cross_detect", instr_valid, 1'b0);
        for (int i = 0; i < L + 1; i++) begin
            tick();
            chk16("cross_maddr", imem.mem_addr, 16'h0008);
            chk1 ("cross_wait", instr_valid, 1'b0);
        end
        tick();
        chk1 ("cross_valid", instr_valid, 1'b1);
        chk16("cross_pc2", instr_pc, 16'h0008);
        chk32("cross_instr", instr, 32'h0B0A0908);
        chk16("cross_maddr_cap", imem.mem_addr, 16'h0008);

        // ---- RUN redirect that misses: one extra detect cycle
        pulse_redirect(16'h0040);
        chk1 ("rd40_detect", instr_valid, 1'b0);
        chk16("rd40_pc", instr_pc, 16'h0040);
        wait_valid(gap);
        chkn ("rd40_gap", gap, L + 2);
        chk32("rd40_instr", instr, mword(16'h0040));

        // ---- far redirect on the third fill cycle of line 0x0008
        pulse_redirect(16'h0008);
        chk1 ("rd08_detect", instr_valid, 1'b0);
        tick();
        chk16("rd08_maddr", imem.mem_addr, 16'h0008);
        tick(); tick();
        chk1 ("rd08_wait", instr_valid, 1'b0);
        pulse_redirect(16'h0100);
        chk16("rd100_maddr", imem.mem_addr, 16'h0100);
        chk16("rd100_pc", instr_pc, 16'h0100);
        chk1 ("rd100_wait", instr_valid, 1'b0);
        wait_valid(gap);
        chkn ("rd100_gap", gap, L + 1);
        chk16("rd100_vpc", instr_pc, 16'h0100);
        chk32("rd100_instr", instr, mword(16'h0100));

        // ---- same-line redirect during fill: capture edge unchanged
        pulse_redirect(16'h0008);
        chk1 ("rd0c_detect", instr_valid, 1'b0);
        tick(); tick();
        pulse_redirect(16'h000E);
        chk16("rd0c_pc", instr_pc, 16'h000C);
        chk16("rd0c_maddr", imem.mem_addr, 16'h0008);
        wait_valid(gap);
        chkn ("rd0c_gap", gap, L + 2 - 3);
        chk16("rd0c_vpc", instr_pc, 16'h000C);
        chk32("rd0c_instr", instr, 32'h0F0E0D0C);

        // ---- PC wrap 0xFFFC -> 0x0000
        pulse_redirect(16'hFFFA);
        chk16("wrap_pc0", instr_pc, 16'hFFF8);
        wait_valid(gap);
        chkn ("wrap_gap", gap, L + 2);
        chk32("wrap_instr0", instr, mword(16'hFFF8));
        tick();
        chk16("wrap_pc1", instr_pc, 16'hFFFC);
        chk32("wrap_instr1", instr, mword(16'hFFFC));
        tick();
        chk16("wrap_pc2", instr_pc, 16'h0000);
        chk1 ("wrap_miss", instr_valid, 1'b0);

        // ---- reset mid-fill aborts immediately
        pulse_redirect(16'h0200);
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk1 ("midrst_valid", instr_valid, 1'b0);
        chk32("midrst_instr", instr, 32'h0);
        chk16("midrst_pc", instr_pc, 16'h0000);
        chk16("midrst_maddr", imem.mem_addr, 16'h0000);
        tick(); tick();
        rst_n = 1'b1;
        wait_valid(gap);
        chkn ("reboot_gap", gap, L + 1);
        chk32("reboot_instr", instr, 32'h03020100);

        // ---- three line crossings after reset
        for (int i = 0; i < 60 && !(instr_valid && instr_pc == 16'h0018); i++) tick();
        chk1 ("run18_reached", instr_valid && (instr_pc == 16'h0018), 1'b1);
        chk32("run18_instr", instr, mword(16'h0018));
`ifdef IFETCH_STATS_EN
        chk16("miss_count3", miss_count, 16'd3);
`endif

        // ---- randomized run against the architectural PC model
        pc_m      = 16'h0018;
        prev_v    = 1'b0;
        prev_line = '0;
        streak    = 0;
        for (int c = 0; c < 3000; c++) begin
            chk16("rnd_pc", instr_pc, pc_m);
            // With a line buffered, validity depends only on the PC's line.
            if (prev_v) chk1("rnd_hitmiss", instr_valid, pc_m[15:3] == prev_line);
            if (instr_valid) begin
                chk32("rnd_instr", instr, mword(pc_m));
                streak = 0;
            end else begin
                streak++;
                chk1("rnd_latency", streak <= L + 2, 1'b1);
            end
            prev_v    = instr_valid;
            prev_line = pc_m[15:3];

            stall    = ($urandom_range(3) == 0);
            redirect = ($urandom_range(11) == 0);
            tgt = ($urandom_range(7) == 0) ? (16'hFFE0 | 16'($urandom_range(31)))
                                           : 16'($urandom_range(255));
            redirect_pc = tgt;

            nxt = pc_m;
            if (redirect) begin
                nxt    = tgt & 16'hFFFC;
                streak = 0;
            end else if (instr_valid && !stall) begin
                nxt = pc_m + 16'd4;
            end
            pc_m = nxt;
            tick();
        end
        stall    = 1'b0;
        redirect = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
